// File: rtl/rv_pkg.sv
// Shared decode definitions for the decode/issue stage: opcode constants,
// register-index type and the per-instruction operand usage decode.
package rv_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [6:0] opc;
        opc         = instr[6:0];
        d.uses_rs1  = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
        d.uses_rs2  = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
        // x0 as destination never creates a dependency
        d.writes_rd = !((opc == OPC_STORE) || (opc == OPC_BRANCH)) && (instr[11:7] != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// One busy bit per architectural register; set on issue, cleared on
// writeback, set wins on a same-cycle collision, bit 0 is hard-wired to 0.
module reg_scoreboard
    import rv_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  reg_idx_t        set_idx,
    input  logic            clr_en,
    input  reg_idx_t        clr_idx,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_d;

    // Clear is applied first so that a set of the same index overrides it
    always_comb begin
        busy_d = busy;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_d;
    end

endmodule

// File: rtl/decode_issue.sv
// In-order decode/issue stage with a register scoreboard and one output
// register toward execute. Define WB_BYPASS_EN to forward same-cycle writeback.
module decode_issue
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    output reg_idx_t        a1,
    output reg_idx_t        a2,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic            wb_valid,
    input  reg_idx_t        wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output reg_idx_t        ex_rd,
    output logic            ex_we
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; a valid producer keeps its payload stable until it transfers.

    reg_idx_t        rs1, rs2, rd;
    dec_t            dec;
    logic [NREG-1:0] busy;
    logic            byp1, byp2;
    logic            hazard, accept;
    logic [XLEN-1:0] op1, op2;

    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];
    assign rd  = in_instr[11:7];
    assign a1  = rs1;
    assign a2  = rs2;
    assign dec = decode(in_instr);

`ifdef WB_BYPASS_EN
    assign byp1 = wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1);
    assign byp2 = wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2);
    assign op1  = byp1 ? wb_data : rd1;
    assign op2  = byp2 ? wb_data : rd2;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign op1  = rd1;
    assign op2  = rd2;
`endif

    assign hazard = (dec.uses_rs1 && busy[rs1] && !byp1)
                  | (dec.uses_rs2 && busy[rs2] && !byp2)
                  | (dec.writes_rd && busy[rd]);
    assign in_ready = !hazard && (!ex_valid || ex_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_instr   <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_rd      <= '0;
            ex_we      <= 1'b0;
        end else if (accept) begin
            ex_valid   <= 1'b1;
            ex_instr   <= in_instr;
            ex_rs1_val <= dec.uses_rs1 ? op1 : '0;
            ex_rs2_val <= dec.uses_rs2 ? op2 : '0;
            ex_rd      <= rd;
            ex_we      <= dec.writes_rd;
        end else if (ex_ready) begin
            ex_valid   <= 1'b0;
        end
    end

    reg_scoreboard #(.NREG(NREG)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (accept && dec.writes_rd),
        .set_idx (rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .busy    (busy)
    );

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the issue rules.
module tb_decode_issue;

  localparam int XLEN = 32;
  localparam logic [6:0] T_LUI = 7'h37, T_AUIPC = 7'h17, T_JAL = 7'h6f, T_JALR = 7'h67;
  localparam logic [6:0] T_OP = 7'h33, T_OPI = 7'h13, T_LOAD = 7'h03, T_ST = 7'h23, T_BR = 7'h63;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [31:0]     in_instr;
  logic            in_ready;
  logic [4:0]      a1, a2;
  logic [XLEN-1:0] rd1, rd2;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid, ex_ready;
  logic [31:0]     ex_instr;
  logic [XLEN-1:0] ex_rs1_val, ex_rs2_val;
  logic [4:0]      ex_rd;
  logic            ex_we;

  logic [XLEN-1:0] regs [32];
  assign rd1 = regs[a1];
  assign rd2 = regs[a2];

  // model state
  bit              m_busy [32];
  bit              m_ex_valid;
  logic [31:0]     m_ex_instr;
  logic [XLEN-1:0] m_rs1, m_rs2;
  logic [4:0]      m_rd;
  bit              m_we;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_issue #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_we(ex_we)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_ex_valid = 0; m_ex_instr = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_we = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ex_valid"}, ex_valid, m_ex_valid);
    check({tag, "_ex_instr"}, ex_instr, m_ex_instr);
    check({tag, "_ex_rs1"}, ex_rs1_val, m_rs1);
    check({tag, "_ex_rs2"}, ex_rs2_val, m_rs2);
    check({tag, "_ex_rd"}, ex_rd, m_rd);
    check({tag, "_ex_we"}, ex_we, m_we);
    check({tag, "_busy"}, dut.busy, model_busy_vec());
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit exr,
                       input bit wbv, input logic [4:0] wbr, input logic [XLEN-1:0] wbd);
    in_valid = v; in_instr = ins; ex_ready = exr;
    wb_valid = wbv; wb_rd = wbr; wb_data = wbd;
  endtask

  // Called at a falling edge with inputs driven; runs one clock and checks it.
  task automatic cycle(input string tag);
    logic [6:0]      opc;
    logic [4:0]      s1, s2, d;
    bit              u1, u2, w, b1, b2, hz, rdy, acc;
    logic [XLEN-1:0] v1, v2;
    #1;
    opc = in_instr[6:0];
    s1 = in_instr[19:15]; s2 = in_instr[24:20]; d = in_instr[11:7];
    u1 = !(opc inside {T_LUI, T_AUIPC, T_JAL});
    u2 = opc inside {T_OP, T_ST, T_BR};
    w  = !(opc inside {T_ST, T_BR}) && d != 0;
`ifdef WB_BYPASS_EN
    b1 = wb_valid && wb_rd != 0 && wb_rd == s1;
    b2 = wb_valid && wb_rd != 0 && wb_rd == s2;
`else
    b1 = 0; b2 = 0;
`endif
    hz  = (u1 && m_busy[s1] && !b1) || (u2 && m_busy[s2] && !b2) || (w && m_busy[d]);
    rdy = !hz && (!m_ex_valid || ex_ready);
    acc = in_valid && rdy;
    v1  = !u1 ? '0 : (b1 ? wb_data : regs[s1]);
    v2  = !u2 ? '0 : (b2 ? wb_data : regs[s2]);
    check({tag, "_a1"}, a1, s1);
    check({tag, "_a2"}, a2, s2);
    check({tag, "_in_ready"}, in_ready, rdy);
    @(posedge clk);
    #1;
    if (acc) begin
      m_ex_valid = 1; m_ex_instr = in_instr; m_rs1 = v1; m_rs2 = v2; m_rd = d; m_we = w;
    end else if (ex_ready) begin
      m_ex_valid = 0;
    end
    if (wb_valid && wb_rd != 0) begin
      m_busy[wb_rd] = 0;
      regs[wb_rd] = wb_data;
    end
    if (acc && w) m_busy[d] = 1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic clear_all();
    for (int i = 1; i < 32; i++) begin
      drive(0, 32'h13, 1, 1, 5'(i), regs[i]);
      cycle("clr");
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [9];
    logic [31:0] r;
    opcs = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_OP, T_OPI, T_LOAD, T_ST, T_BR};
    r = $urandom;
    r[6:0]   = opcs[$urandom_range(0, 8)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  logic [31:0] held;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? '0 : $urandom;
    regs[1] = 5; regs[2] = 7;
    rst_n = 0;
    drive(0, '0, 1, 0, '0, '0);
    model_reset();
    #3;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // ADD x3,x1,x2
    drive(1, 32'h002081B3, 1, 0, 0, 0);
    cycle("add");
    check("add_rs1_5", ex_rs1_val, 5);
    check("add_rs2_7", ex_rs2_val, 7);
    check("add_busy3", dut.busy[3], 1);

    // ADDI x4,x3,1 behind a pending x3, then writeback of 12 to x3
    drive(1, 32'h00118213, 1, 0, 0, 0);
    cycle("raw_stall");
    check("raw_stall_ready", in_ready, 0);
    drive(1, 32'h00118213, 1, 1, 3, 12);
    cycle("raw_wb");
    drive(1, 32'h00118213, 1, 0, 0, 0);
    cycle("raw_after");
    check("raw_rs1_12", ex_rs1_val, 12);
    check("raw_instr", ex_instr, 32'h00118213);
    drive(0, 32'h13, 1, 1, 4, 33);
    cycle("raw_drain");

    // backpressure: ADD x6 issues, then execute stalls three cycles
    drive(1, 32'h00208333, 1, 0, 0, 0);
    cycle("bp_issue");
    held = ex_instr;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h002083B3, 0, 0, 0, 0);
      cycle("bp_hold");
      check("bp_hold_stable", ex_instr, 32'h00208333);
      check("bp_hold_ready", in_ready, 0);
    end
    for (int n = 7; n <= 10; n++) begin
      drive(1, (32'd1 << 20) | (32'd1 << 15) | (32'(n) << 7) | 32'h13, 1, 0, 0, 0);
      cycle("bp_b2b");
      check("bp_b2b_valid", ex_valid, 1);
      check("bp_b2b_rd", ex_rd, 5'(n));
    end
    clear_all();

    // writes to x0 and stores never mark a register busy
    drive(1, 32'h00000013, 1, 0, 0, 0);
    cycle("nop");
    check("nop_we", ex_we, 0);
    check("nop_busy", dut.busy, 0);
    drive(1, 32'h0020A023, 1, 0, 0, 0);
    cycle("sw");
    check("sw_we", ex_we, 0);
    check("sw_rs1", ex_rs1_val, 5);
    check("sw_rs2", ex_rs2_val, 7);
    drive(1, 32'h123454B7, 1, 0, 0, 0);
    cycle("lui");
    check("lui_rs1_zero", ex_rs1_val, 0);
    check("lui_rs2_zero", ex_rs2_val, 0);
    clear_all();

    // issue of x5 collides with writeback of x5: busy must stay set
    drive(1, 32'h00108293, 1, 1, 5, regs[5]);
    cycle("setclr");
    check("setclr_busy5", dut.busy[5], 1);
    clear_all();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
      cycle("rnd");
    end
    clear_all();

    // asynchronous reset with a held instruction and x3 busy
    drive(1, 32'h002081B3, 0, 0, 0, 0);
    cycle("pre_rst");
    check("pre_rst_valid", ex_valid, 1);
    check("pre_rst_busy3", dut.busy[3], 1);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter XLEN, default 32, data width of register values.
REQ-002 Parameter NREG, default 32, number of architectural registers; index width 5.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1; in_instr  input  32; in_ready  output  1 -- fetched-instruction handshake.
REQ-006 Port a1, a2  output  5  register-file read addresses (rs1, rs2); rd1, rd2  input  XLEN  combinational read data.
REQ-007 Port wb_valid  input  1; wb_rd  input  5; wb_data  input  XLEN -- writeback event, same cycle as register-file write.
REQ-008 Port ex_valid  output  1; ex_ready  input  1; ex_instr  output  32; ex_rs1_val, ex_rs2_val  output  XLEN; ex_rd  output  5; ex_we  output  1 -- issue to execute.

Function
REQ-009 a1 = in_instr[19:15], a2 = in_instr[24:20] combinationally, regardless of in_valid.
REQ-010 uses_rs1 SHALL be 0 for opcodes LUI 0110111, AUIPC 0010111, JAL 1101111, else 1.
REQ-011 uses_rs2 SHALL be 1 only for opcodes 0110011 (OP), 0100011 (STORE), 1100011 (BRANCH).
REQ-012 writes_rd SHALL be 0 for STORE and BRANCH and whenever rd = in_instr[11:7] = 0.
REQ-013 Scoreboard: one busy bit per register; bit 0 is always 0.
REQ-014 hazard = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (writes_rd & busy[rd]).
REQ-015 in_ready = !hazard & (!ex_valid | ex_ready).
REQ-016 Accept = in_valid & in_ready; on accept, output register loads instr, operand values, rd, we=writes_rd, and ex_valid=1 next cycle (latency 1).
REQ-017 ex_valid with no accept and ex_ready=1 SHALL clear; with ex_ready=0, all ex_* outputs SHALL hold stable.
REQ-018 On accept with writes_rd, busy[rd] SHALL set next cycle.
REQ-019 wb_valid with wb_rd != 0 SHALL clear busy[wb_rd] next cycle.
REQ-020 Simultaneous set and clear of the same bit: set wins.
REQ-021 Operands not used SHALL be captured as 0.

Reset
REQ-022 rst_n low SHALL immediately force ex_valid=0, busy all 0, ex_instr=0, ex_rs1_val=0, ex_rs2_val=0, ex_rd=0, ex_we=0.
REQ-023 Reset mid-operation discards the held instruction; no scoreboard state survives.

Configuration
REQ-024 Macro WB_BYPASS_EN defined: if wb_valid and wb_rd != 0 equals rs1/rs2, that operand's busy bit is ignored in REQ-014 and wb_data replaces rd1/rd2 at capture.
REQ-025 Macro undefined: no bypass; an instruction waits until the busy bit is clear at the start of a cycle (one extra stall cycle per RAW).

Structure
REQ-026 Opcode constants and the 5-bit register-index typedef SHALL live in package rv_pkg.
REQ-027 Busy-bit array and its set/clear logic SHALL be sub-module reg_scoreboard (ports: clk, rst_n, set_en, set_idx, clr_en, clr_idx, busy vector).

Verification
REQ-028 Issue ADD x3,x1,x2 (0x002081B3), rd1=5, rd2=7, ex_ready=1 -> next cycle ex_valid=1, ex_rs1_val=5, ex_rs2_val=7, ex_rd=3, ex_we=1, busy[3]=1.
REQ-029 Next ADDI x4,x3,1 (0x00118213) while busy[3] -> in_ready=0; wb_valid wb_rd=3 wb_data=12 -> with WB_BYPASS_EN accepted that cycle, ex_rs1_val=12; without, accepted one cycle later using rd1.
REQ-030 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, in_ready=0; ex_ready=1 -> back-to-back accepts resume, one per cycle.
REQ-031 ADDI x0,x0,0 (0x00000013) -> ex_we=0, no busy bit set; STORE SW x2,0(x1) -> ex_we=0, uses both operands.
REQ-032 Same-cycle accept writing x5 and wb_rd=5 -> busy[5]=1 afterwards.
REQ-033 rst_n asserted while ex_valid=1 and busy[3]=1 -> ex_valid=0 and busy cleared immediately, without waiting for clk.
